// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated-FIFO subsystem.
//   - Default FIFO count, data width and index width.
//   - arb_idx_t: source-index type for the default FIFO count.
//   - rr_next(): rotate-priority-encode helper used by rr_arbiter.
package arb_pkg;

    localparam int ARB_NUM_FIFOS = 4;
    localparam int ARB_QWID      = $clog2(ARB_NUM_FIFOS);
    localparam int FIFO_DWIDTH   = 8;

    // The helper works on a fixed maximum width; callers zero-extend.
    localparam int RR_MAX_QWID   = 5;
    localparam int RR_MAX_FIFOS  = 32;

    typedef logic [ARB_QWID-1:0] arb_idx_t;

    // Returns {any, index} of the first set req bit scanning ptr+1,
    // ptr+2, ... modulo n. ptr must be below n.
    function automatic logic [RR_MAX_QWID:0] rr_next(
        input logic [RR_MAX_FIFOS-1:0] req,
        input logic [RR_MAX_QWID-1:0]  ptr,
        input logic [RR_MAX_QWID:0]    n
    );
        logic                   found;
        logic [RR_MAX_QWID-1:0] idx;
        logic [RR_MAX_QWID:0]   cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= RR_MAX_FIFOS; k++) begin
            // ptr < n and k <= n, so one subtraction is a full modulo.
            cand = {1'b0, ptr} + (RR_MAX_QWID+1)'(k);
            if (cand >= n) begin
                cand = cand - n;
            end else begin
                cand = cand;
            end
            if (!found && ((RR_MAX_QWID+1)'(k) <= n) && req[cand[RR_MAX_QWID-1:0]]) begin
                found = 1'b1;
                idx   = cand[RR_MAX_QWID-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req       in  N   request vector
//   ptr       in  QW  index of the last grant; scan starts at ptr+1
//   grant     out N   one-hot grant (zero when no request)
//   grant_idx out QW  index of the granted requester
//   any       out 1   at least one request present
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N  = ARB_NUM_FIFOS,
    parameter int QW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [QW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [QW-1:0] grant_idx,
    output logic          any
);

    logic [RR_MAX_FIFOS-1:0] req_ext_s;
    logic [RR_MAX_QWID-1:0]  ptr_ext_s;
    logic [RR_MAX_QWID:0]    res_s;
    logic                    unused_res_bits_s;

    // Widen to the helper's width, encode, and expand to one-hot.
    always_comb begin
        req_ext_s        = '0;
        req_ext_s[N-1:0] = req;
        ptr_ext_s         = '0;
        ptr_ext_s[QW-1:0] = ptr;
        res_s     = rr_next(req_ext_s, ptr_ext_s, (RR_MAX_QWID+1)'(N));
        any       = res_s[RR_MAX_QWID];
        grant_idx = res_s[QW-1:0];
        grant     = '0;
        if (res_s[RR_MAX_QWID]) begin
            grant[res_s[QW-1:0]] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    // Upper index bits are always zero for N below the helper maximum.
    assign unused_res_bits_s = ^res_s;

endmodule

// File: rtl/fifo_arb_reader.sv
// Read side of the arbitrated-FIFO subsystem. Drains NUM_FIFOS
// first-word-fall-through FIFOs round-robin onto one valid/ready stream,
// tagging each word with its source FIFO index.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   start       level enable; no pops while low
//   fifo_empty  per-FIFO empty flag
//   fifo_data   per-FIFO head word, FIFO i at [i*WIDTH +: WIDTH]
//   fifo_pop    per-FIFO pop, one-hot or zero, combinational
//   out_valid   output register holds a word
//   out_ready   downstream accepts this cycle
//   out_data    popped word
//   out_id      source FIFO index of out_data
//   grant_cnt   saturating count of pops since reset
module fifo_arb_reader
    import arb_pkg::*;
#(
    parameter int WIDTH     = FIFO_DWIDTH,
    parameter int NUM_FIFOS = ARB_NUM_FIFOS,
    parameter int QWID      = $clog2(NUM_FIFOS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_FIFOS-1:0]       fifo_empty,
    input  logic [NUM_FIFOS*WIDTH-1:0] fifo_data,
    output logic [NUM_FIFOS-1:0]       fifo_pop,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [QWID-1:0]            out_id,
    output logic [15:0]                grant_cnt
);

    logic [QWID-1:0]      rr_ptr_q,    rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [QWID-1:0]      out_id_q,    out_id_d;
    logic [15:0]          grant_cnt_q, grant_cnt_d;

    logic [NUM_FIFOS-1:0] req_s;
    logic [NUM_FIFOS-1:0] grant_s;
    logic [QWID-1:0]      grant_idx_s;
    logic                 any_s;
    logic                 slot_free_s;
    logic                 pop_s;
    logic [WIDTH-1:0]     sel_data_s;

    assign req_s = ~fifo_empty & {NUM_FIFOS{start}};

    rr_arbiter #(
        .N  (NUM_FIFOS),
        .QW (QWID)
    ) u_rr_arbiter (
        .req       (req_s),
        .ptr       (rr_ptr_q),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    // Pop decision, head-word mux and next-state for the output register.
    always_comb begin
        slot_free_s = !out_valid_q || out_ready;
        pop_s       = slot_free_s && any_s;
        sel_data_s  = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (grant_s[i]) begin
                sel_data_s = fifo_data[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end

        // Gated by rst so no FIFO is popped while the register is held in reset.
        if (pop_s && !rst) begin
            fifo_pop = grant_s;
        end else begin
            fifo_pop = '0;
        end

        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        grant_cnt_d = grant_cnt_q;
        if (pop_s) begin
            // Accept-and-refill in the same cycle keeps 1 word/cycle.
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_id_d    = grant_idx_s;
            rr_ptr_d    = grant_idx_s;
            if (grant_cnt_q != 16'hFFFF) begin
                grant_cnt_d = grant_cnt_q + 16'd1;
            end else begin
                grant_cnt_d = grant_cnt_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register, round-robin pointer and pop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= QWID'(NUM_FIFOS-1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            grant_cnt_q <= 16'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_fifo_arb_reader.sv
// Self-checking bench for fifo_arb_reader: bench-side FIFO queues, an
// independent arbiter model feeding a scoreboard, and per-scenario tasks.
module tb_fifo_arb_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_data;
    logic [3:0]  fifo_pop;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic [15:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } sb_t;

    logic [7:0] fq [4][$];
    sb_t        sb [$];

    // Reference model state
    logic [1:0]  m_ptr   = 2'd3;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt   = 16'd0;
    logic        pend    = 1'b0;
    logic [1:0]  pend_g  = 2'd0;

    fifo_arb_reader #(.WIDTH(8), .NUM_FIFOS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fifo_data[i*8 +: 8] = (fq[i].size() == 0) ? 8'h00 : fq[i][0];
        end
    endtask

    // Reset clears the model; the held word is treated as lost.
    always @(posedge rst) begin
        m_ptr   = 2'd3;
        m_valid = 1'b0;
        m_cnt   = 16'd0;
        pend    = 1'b0;
        sb.delete();
    end

    // Apply the model's pop to the bench FIFOs just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (pend && !rst) begin
            void'(fq[pend_g].pop_front());
        end
        pend = 1'b0;
        refresh();
    end

    // Monitor: predict pops, check outputs against the scoreboard.
    always @(negedge clk) begin
        logic [3:0] req;
        logic [3:0] exp_pop;
        logic       found;
        logic [1:0] g;
        sb_t        e;
        if (!rst) begin
            req     = ~fifo_empty & {4{start}};
            exp_pop = 4'b0000;
            found   = 1'b0;
            g       = 2'd0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req[(int'(m_ptr) + k) % 4]) begin
                    found = 1'b1;
                    g = 2'((int'(m_ptr) + k) % 4);
                end
            end
            if (found && (!m_valid || out_ready)) exp_pop[g] = 1'b1;

            checks++;
            if (fifo_pop !== exp_pop) begin
                errors++;
                $display("FAIL mon_pop actual=%b required=%b t=%0t", fifo_pop, exp_pop, $time);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL mon_valid actual=%b required=%b t=%0t", out_valid, m_valid, $time);
            end
            checks++;
            if (grant_cnt !== m_cnt) begin
                errors++;
                $display("FAIL mon_cnt actual=%0d required=%0d t=%0t", grant_cnt, m_cnt, $time);
            end
            if (m_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty actual=word required=none t=%0t", $time);
                end else begin
                    e = sb.pop_front();
                    if (out_id !== e.id || out_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_word actual=%0d/%h required=%0d/%h t=%0t",
                                 out_id, out_data, e.id, e.data, $time);
                    end
                end
            end
            if (exp_pop != 4'b0000) begin
                sb.push_back('{id: g, data: fq[g][0]});
                m_ptr   = g;
                m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                pend    = 1'b1;
                pend_g  = g;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fq[0].push_back(8'h10); fq[1].push_back(8'h11);
        fq[2].push_back(8'h12); fq[3].push_back(8'h13);
        refresh();
        @(negedge clk);
        checks++;
        if (fifo_pop !== 4'b0000 || out_valid !== 1'b0 || grant_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state actual=%b/%b/%0d required=0000/0/0", fifo_pop, out_valid, grant_cnt);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_pop !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_pop actual=%b required=0001", fifo_pop);
        end
        @(negedge clk);
        checks++;
        if (out_id !== 2'd0 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL reset_first_word actual=%0d/%h required=0/10", out_id, out_data);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_d  [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        start = 1'b0;
        do_reset();
        fq[0].push_back(8'hA0); fq[0].push_back(8'hA4);
        fq[1].push_back(8'hA1); fq[2].push_back(8'hA2); fq[3].push_back(8'hA3);
        refresh();
        @(posedge clk); #2;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_id !== exp_id[k] || out_data !== exp_d[k]) begin
                errors++;
                $display("FAIL rr_seq%0d actual=%b/%0d/%h required=1/%0d/%h",
                         k, out_valid, out_id, out_data, exp_id[k], exp_d[k]);
            end
        end
        checks++;
        if (grant_cnt !== 16'd5) begin
            errors++;
            $display("FAIL rr_cnt actual=%0d required=5", grant_cnt);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall();
        start = 1'b0;
        out_ready = 1'b0;
        do_reset();
        fq[2].push_back(8'h5C); fq[3].push_back(8'h77);
        refresh();
        @(posedge clk); #2;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 8'h5C || fifo_pop !== 4'b0000) begin
                errors++;
                $display("FAIL stall%0d actual=%b/%0d/%h/%b required=1/2/5c/0000",
                         k, out_valid, out_id, out_data, fifo_pop);
            end
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_pop !== 4'b1000) begin
            errors++;
            $display("FAIL stall_release_pop actual=%b required=1000", fifo_pop);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sparse_wrap();
        logic [1:0] exp_id [5] = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd1};
        logic [7:0] exp_d  [5] = '{8'hB0, 8'hD0, 8'hB1, 8'hB2, 8'hB3};
        start = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) fq[1].push_back(8'(8'hB0 + k));
        fq[3].push_back(8'hD0);
        refresh();
        @(posedge clk); #2;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_id !== exp_id[k] || out_data !== exp_d[k]) begin
                errors++;
                $display("FAIL sparse_seq%0d actual=%b/%0d/%h required=1/%0d/%h",
                         k, out_valid, out_id, out_data, exp_id[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_empty_start();
        // Continues from sparse: all FIFOs drained, rr_ptr = 1.
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== 4'b0000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle actual=%b/%b required=0000/0", fifo_pop, out_valid);
            end
        end
        @(posedge clk); #2;
        start = 1'b0;
        fq[0].push_back(8'hE0); fq[2].push_back(8'hE2);
        refresh();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== 4'b0000) begin
                errors++;
                $display("FAIL start_low_pop actual=%b required=0000", fifo_pop);
            end
        end
        @(posedge clk); #2;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_pop !== 4'b0100) begin
            errors++;
            $display("FAIL start_resume_pop actual=%b required=0100", fifo_pop);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        do_reset();
        fq[0].push_back(8'hF0); fq[0].push_back(8'hF1); fq[0].push_back(8'hF2);
        fq[1].push_back(8'hF3);
        refresh();
        @(posedge clk); #2;
        start = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_wait_valid actual=timeout required=out_valid");
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || grant_cnt !== 16'd0 || fifo_pop !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_state actual=%b/%0d/%b required=0/0/0000", out_valid, grant_cnt, fifo_pop);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_pop !== 4'b0001 || start !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ptr actual=%b required=0001", fifo_pop);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        fifo_empty = 4'hF;
        fifo_data = 32'd0;
        test_reset();
        test_round_robin();
        test_stall();
        test_sparse_wrap();
        test_empty_start();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
